// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants, size/state encodings and helpers for
// the byte-serialising RAM arbiter.
package mem_arbiter_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam logic [1:0]  SizeByte    = 2'b00;
    localparam logic [1:0]  SizeHalf    = 2'b01;
    localparam logic [1:0]  SizeWord    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    // Number of byte accesses for a MEM transaction; 2'b11 behaves as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SizeByte: n = 3'd1;
            SizeHalf: n = 3'd2;
            SizeWord: n = 3'd4;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_fetch_buf.sv
// mem_fetch_buf: one-entry instruction buffer {valid, addr, inst} with hit
// compare. Only built when FETCH_BUF_EN is defined; otherwise this file is
// empty and the arbiter ties the hit off.
`ifdef FETCH_BUF_EN
module mem_fetch_buf
    import mem_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fill,
    input  logic [31:0] i_fill_addr,
    input  logic [31:0] i_fill_inst,
    input  logic        i_clear,
    input  logic [31:0] i_lookup_addr,
    output logic        o_hit,
    output logic [31:0] o_inst
);

    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_inst;

    // Clear wins over fill so a store or flush can never leave stale code behind.
    always_ff @(posedge i_clk) begin
        if (i_rst == RstEnable) begin
            r_valid <= 1'b0;
            r_addr  <= ZeroWord;
            r_inst  <= ZeroWord;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_addr  <= i_fill_addr;
            r_inst  <= i_fill_inst;
        end
    end

    assign o_hit  = r_valid && (r_addr == i_lookup_addr);
    assign o_inst = r_inst;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and
// the MEM stage, serialising 8/16/32-bit accesses into bytes and assembling
// read data little-endian. Optional one-entry fetch buffer under the macro
// FETCH_BUF_EN (instantiates mem_fetch_buf).
//
// state   | meaning
// IDLE    | waiting; MEM request wins over IF, IF grant blocked by flush
// IF_RD   | issuing the 4 fetch addresses and capturing bytes one cycle later
// MEM_RD  | issuing 1/2/4 load addresses and capturing bytes one cycle later
// MEM_WR  | writing 1/2/4 store bytes, one per cycle
// DONE    | owner's done pulse is visible; requests ignored; back to IDLE
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_if_req,
    input  logic [InstAddrBus-1:0] i_if_addr,
    output logic                   o_if_done,
    output logic [InstBus-1:0]     o_if_inst,
    input  logic                   i_mem_req,
    input  logic                   i_mem_we,
    input  logic [1:0]             i_mem_size,
    input  logic [31:0]            i_mem_addr,
    input  logic [31:0]            i_mem_wdata,
    output logic                   o_mem_done,
    output logic [31:0]            o_mem_rdata,
    input  logic                   i_flush,
    output logic                   o_busy,
    output logic [31:0]            o_ram_addr,
    output logic                   o_ram_wr,
    output logic [7:0]             o_ram_dout,
    input  logic [7:0]             i_ram_din
);

    arb_state_t  r_state;
    arb_owner_t  r_owner;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic [2:0]  r_n;
    logic [2:0]  r_cnt;

    logic        r_if_done;
    logic [31:0] r_if_inst;
    logic        r_mem_done;
    logic [31:0] r_mem_rdata;
    logic        r_busy;
    logic [31:0] r_ram_addr;
    logic        r_ram_wr;
    logic [7:0]  r_ram_dout;

    logic [2:0]  w_cnt_nx;
    logic [31:0] w_capture;
    logic [7:0]  w_wbyte_nx;
    logic        w_if_complete;
    logic        w_buf_hit;
    logic [31:0] w_buf_inst;

    assign w_cnt_nx      = r_cnt + 3'd1;
    assign w_if_complete = (r_state == ST_IF_RD) && (r_cnt == r_n) && !i_flush;

    // In read states cnt runs one ahead of the byte arriving on ram_din.
    always_comb begin
        w_capture = r_data;
        case (r_cnt)
            3'd1:    w_capture[7:0]   = i_ram_din;
            3'd2:    w_capture[15:8]  = i_ram_din;
            3'd3:    w_capture[23:16] = i_ram_din;
            3'd4:    w_capture[31:24] = i_ram_din;
            default: w_capture = r_data;
        endcase
    end

    // Store byte for the next write cycle.
    always_comb begin
        w_wbyte_nx = r_wdata[7:0];
        case (w_cnt_nx[1:0])
            2'd1:    w_wbyte_nx = r_wdata[15:8];
            2'd2:    w_wbyte_nx = r_wdata[23:16];
            2'd3:    w_wbyte_nx = r_wdata[31:24];
            default: w_wbyte_nx = r_wdata[7:0];
        endcase
    end

`ifdef FETCH_BUF_EN
    mem_fetch_buf u_fetch_buf (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_fill        (w_if_complete),
        .i_fill_addr   (r_base),
        .i_fill_inst   (w_capture),
        .i_clear       (i_flush | r_ram_wr),
        .i_lookup_addr (i_if_addr),
        .o_hit         (w_buf_hit),
        .o_inst        (w_buf_inst)
    );
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_inst = ZeroWord;
`endif

    // Arbitration FSM; every output is registered from the next-state decision.
    always_ff @(posedge i_clk) begin
        if (i_rst == RstEnable) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_base      <= ZeroWord;
            r_wdata     <= ZeroWord;
            r_data      <= ZeroWord;
            r_n         <= 3'd0;
            r_cnt       <= 3'd0;
            r_if_done   <= 1'b0;
            r_if_inst   <= ZeroWord;
            r_mem_done  <= 1'b0;
            r_mem_rdata <= ZeroWord;
            r_busy      <= 1'b0;
            r_ram_addr  <= ZeroWord;
            r_ram_wr    <= 1'b0;
            r_ram_dout  <= 8'h00;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_mem_req) begin
                        r_owner    <= OWN_MEM;
                        r_base     <= i_mem_addr;
                        r_wdata    <= i_mem_wdata;
                        r_n        <= byte_count(i_mem_size);
                        r_cnt      <= 3'd0;
                        r_data     <= ZeroWord;
                        r_ram_addr <= i_mem_addr;
                        r_busy     <= 1'b1;
                        if (i_mem_we) begin
                            r_state    <= ST_MEM_WR;
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= i_mem_wdata[7:0];
                        end else begin
                            r_state <= ST_MEM_RD;
                        end
                    end else if (i_if_req && !i_flush) begin
                        r_owner <= OWN_IF;
                        r_base  <= i_if_addr;
                        r_n     <= 3'd4;
                        r_cnt   <= 3'd0;
                        r_data  <= ZeroWord;
                        r_busy  <= 1'b1;
                        if (w_buf_hit) begin
                            // Buffered instruction: complete without touching the RAM.
                            r_state   <= ST_DONE;
                            r_if_done <= 1'b1;
                            r_if_inst <= w_buf_inst;
                        end else begin
                            r_state    <= ST_IF_RD;
                            r_ram_addr <= i_if_addr;
                        end
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    if ((r_state == ST_IF_RD) && i_flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_data <= w_capture;
                        r_cnt  <= w_cnt_nx;
                        if (w_cnt_nx < r_n) begin
                            r_ram_addr <= r_base + {29'd0, w_cnt_nx};
                        end
                        if (r_cnt == r_n) begin
                            r_state <= ST_DONE;
                            if (r_owner == OWN_IF) begin
                                r_if_done <= 1'b1;
                                r_if_inst <= w_capture;
                            end else begin
                                r_mem_done  <= 1'b1;
                                r_mem_rdata <= w_capture;
                            end
                        end
                    end
                end
                ST_MEM_WR: begin
                    r_cnt <= w_cnt_nx;
                    if (w_cnt_nx == r_n) begin
                        r_state    <= ST_DONE;
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
                    end else begin
                        r_ram_addr <= r_base + {29'd0, w_cnt_nx};
                        r_ram_dout <= w_wbyte_nx;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_ram_wr <= 1'b0;
                end
            endcase
        end
    end

    assign o_if_done   = r_if_done;
    assign o_if_inst   = r_if_inst;
    assign o_mem_done  = r_mem_done;
    assign o_mem_rdata = r_mem_rdata;
    assign o_busy      = r_busy;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wr    = r_ram_wr;
    assign o_ram_dout  = r_ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transactions against a transaction-level model
// (byte array + latency rules). Follows FETCH_BUF_EN for buffer-hit timing.
module tb_mem_arbiter;

`ifdef FETCH_BUF_EN
    localparam bit BUF_ON = 1'b1;
`else
    localparam bit BUF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_done;
    logic [31:0] o_if_inst;
    logic        i_mem_req;
    logic        i_mem_we;
    logic [1:0]  i_mem_size;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic        o_mem_done;
    logic [31:0] o_mem_rdata;
    logic        i_flush;
    logic        o_busy;
    logic [31:0] o_ram_addr;
    logic        o_ram_wr;
    logic [7:0]  o_ram_dout;
    logic [7:0]  i_ram_din;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_done   (o_if_done),
        .o_if_inst   (o_if_inst),
        .i_mem_req   (i_mem_req),
        .i_mem_we    (i_mem_we),
        .i_mem_size  (i_mem_size),
        .i_mem_addr  (i_mem_addr),
        .i_mem_wdata (i_mem_wdata),
        .o_mem_done  (o_mem_done),
        .o_mem_rdata (o_mem_rdata),
        .i_flush     (i_flush),
        .o_busy      (o_busy),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wr    (o_ram_wr),
        .o_ram_dout  (o_ram_dout),
        .i_ram_din   (i_ram_din)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Unwritten locations read as a fixed address hash.
    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    // RAM device attached to the DUT port: synchronous read, byte write.
    logic [7:0] ram_mem [logic [31:0]];
    int         nwr = 0;

    function automatic logic [7:0] ram_get(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return dflt(a);
    endfunction

    always @(posedge clk) begin
        i_ram_din <= ram_get(o_ram_addr);
        if (o_ram_wr) begin
            ram_mem[o_ram_addr] = o_ram_dout;
            nwr <= nwr + 1;
        end
    end

    // Reference model state.
    logic [7:0]  ref_mem [logic [31:0]];
    int          exp_nwr = 0;
    logic [31:0] exp_if_inst = 32'h0;
    logic [31:0] exp_mem_rdata = 32'h0;
    bit          bv = 1'b0;
    logic [31:0] ba = 32'h0;

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ref_rd(a + 32'(i));
        return r;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    task automatic preset(input logic [31:0] a, input logic [7:0] d);
        ram_mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_if_done"},   {31'd0, o_if_done},  32'd0);
        chk({tag, "_mem_done"},  {31'd0, o_mem_done}, 32'd0);
        chk({tag, "_busy"},      {31'd0, o_busy},     32'd0);
        chk({tag, "_ram_wr"},    {31'd0, o_ram_wr},   32'd0);
        chk({tag, "_if_inst"},   o_if_inst,           32'd0);
        chk({tag, "_mem_rdata"}, o_mem_rdata,         32'd0);
        chk({tag, "_ram_addr"},  o_ram_addr,          32'd0);
        chk({tag, "_ram_dout"},  {24'd0, o_ram_dout}, 32'd0);
    endtask

    // One scenario starting in an IDLE cycle (cycle 0). flush_at < 0: no flush.
    // A flush with only do_if set aborts the fetch; with do_mem it must be ignored.
    task automatic run_txn(input bit do_if, input logic [31:0] if_a,
                           input bit do_mem, input bit we, input logic [1:0] sz,
                           input logic [31:0] ma, input logic [31:0] wd,
                           input int flush_at);
        int n, mem_exp, if_exp, end_k, mem_lat, if_lat, mem_cnt, if_cnt, busy_ff;
        bit hit, flush_if;
        logic [31:0] exp_inst, exp_rd, got_inst, got_rd, addr0;

        n        = size_bytes(sz);
        flush_if = do_if && !do_mem && (flush_at >= 0);
        hit      = 1'b0;
        mem_exp  = 0;
        if_exp   = 0;
        exp_rd   = 32'h0;
        exp_inst = 32'h0;

        if (do_mem) begin
            mem_exp = we ? n + 1 : n + 2;
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[ma + 32'(i)] = wd[8*i +: 8];
                exp_nwr += n;
                bv = 1'b0;
            end else begin
                exp_rd = ref_load(ma, n);
                exp_mem_rdata = exp_rd;
            end
            if (flush_at >= 0) bv = 1'b0;
        end
        if (do_if) begin
            hit      = BUF_ON && bv && (ba == if_a);
            if_exp   = (do_mem ? mem_exp + 1 : 0) + (hit ? 1 : 6);
            exp_inst = ref_load(if_a, 4);
            if (flush_if) begin
                bv = 1'b0;
            end else begin
                bv          = BUF_ON;
                ba          = if_a;
                exp_if_inst = exp_inst;
            end
        end
        end_k = flush_if ? flush_at + 2 : ((if_exp > mem_exp ? if_exp : mem_exp) + 2);

        addr0       = o_ram_addr;
        i_if_req    = do_if;
        i_if_addr   = if_a;
        i_mem_req   = do_mem;
        i_mem_we    = we;
        i_mem_size  = sz;
        i_mem_addr  = ma;
        i_mem_wdata = wd;
        i_flush     = (flush_at == 0);
        mem_lat = -1; if_lat = -1; mem_cnt = 0; if_cnt = 0; busy_ff = -1;
        got_inst = 32'h0; got_rd = 32'h0;

        for (int k = 1; k <= end_k; k++) begin
            @(posedge clk); #1;
            if (o_mem_done) begin
                mem_cnt++;
                if (mem_lat < 0) begin mem_lat = k; got_rd = o_mem_rdata; end
                i_mem_req = 1'b0;
            end
            if (o_if_done) begin
                if_cnt++;
                if (if_lat < 0) begin if_lat = k; got_inst = o_if_inst; end
                i_if_req = 1'b0;
            end
            if (flush_if && k == flush_at + 1) busy_ff = {31'd0, o_busy};
            i_flush = (k == flush_at);
            if (flush_if && k >= flush_at) i_if_req = 1'b0;
        end
        i_if_req  = 1'b0;
        i_mem_req = 1'b0;
        i_flush   = 1'b0;

        if (do_mem) begin
            chk("mem_lat", mem_lat, mem_exp);
            chk("mem_pulses", mem_cnt, 1);
            if (!we) chk("mem_rdata", got_rd, exp_rd);
            else for (int i = 0; i < n; i++)
                chk("store_byte", {24'd0, ram_get(ma + 32'(i))}, {24'd0, wd[8*i +: 8]});
        end
        if (do_if && !flush_if) begin
            chk("if_lat", if_lat, if_exp);
            chk("if_pulses", if_cnt, 1);
            chk("if_inst", got_inst, exp_inst);
            if (hit && !do_mem) chk("hit_ram_addr", o_ram_addr, addr0);
        end
        if (flush_if) begin
            chk("flush_if_done", if_cnt, 0);
            chk("flush_busy", busy_ff, 0);
        end
        chk("if_inst_hold", o_if_inst, exp_if_inst);
        chk("mem_rdata_hold", o_mem_rdata, exp_mem_rdata);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);
        chk("write_count", nwr, exp_nwr);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0100 + 32'($urandom_range(0, 15));
            1:       return 32'h0000_0200 + 32'($urandom_range(0, 15));
            2:       return 32'h0001_FFF0 + 32'($urandom_range(0, 15));
            3:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          kind;
        logic [31:0] a, b, wd;
        logic [1:0]  sz;
        logic [31:0] last_if;

        i_rst = 1'b1; i_if_req = 1'b0; i_if_addr = 32'h0; i_mem_req = 1'b0;
        i_mem_we = 1'b0; i_mem_size = 2'b00; i_mem_addr = 32'h0; i_mem_wdata = 32'h0;
        i_flush = 1'b0;
        last_if = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        i_rst = 1'b0;
        @(posedge clk); #1;

        // Word fetch of addi-style encoding.
        preset(32'h100, 8'h13); preset(32'h101, 8'h05);
        preset(32'h102, 8'h00); preset(32'h103, 8'h00);
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0, -1);

        // Simultaneous requests: MEM byte load first, then IF.
        preset(32'h200, 8'hA5);
        run_txn(1, 32'h104, 1, 0, 2'b00, 32'h200, 32'h0, -1);

        // Half store.
        run_txn(0, 32'h0, 1, 1, 2'b01, 32'h0001_FFFE, 32'h1234_BEEF, -1);

        // Flush in cycle 3 of a fetch.
        run_txn(1, 32'h108, 0, 0, 2'b00, 32'h0, 32'h0, 3);

        // Refetch (buffer hit when enabled), then store and refetch again.
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0, -1);
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0, -1);
        run_txn(0, 32'h0, 1, 1, 2'b00, 32'h5000, 32'h0000_0077, -1);
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0, -1);

        for (int it = 0; it < 150; it++) begin
            kind = int'($urandom_range(0, 5));
            a    = pick_addr();
            b    = pick_addr();
            wd   = $urandom();
            sz   = 2'($urandom_range(0, 3));
            case (kind)
                0: begin
                    if ($urandom_range(0, 1) == 1) a = last_if;
                    run_txn(1, a, 0, 0, 2'b00, 32'h0, 32'h0, -1);
                    last_if = a;
                end
                1: run_txn(0, 32'h0, 1, 0, sz, a, 32'h0, -1);
                2: run_txn(0, 32'h0, 1, 1, sz, a, wd, -1);
                3: begin
                    if ($urandom_range(0, 1) == 1) b = last_if;
                    run_txn(1, b, 1, 1'($urandom_range(0, 1)), sz, a, wd, -1);
                    last_if = b;
                end
                4: begin
                    if (bv && a == ba) a = a + 32'd4;
                    run_txn(1, a, 0, 0, 2'b00, 32'h0, 32'h0, int'($urandom_range(0, 5)));
                end
                default: run_txn(0, 32'h0, 1, 1'($urandom_range(0, 1)), sz, a, wd,
                                 int'($urandom_range(1, size_bytes(sz) + 1)));
            endcase
        end

        // Reset during a word store: the reset edge ends cycle 1, so only byte 0 lands.
        i_mem_req = 1'b1; i_mem_we = 1'b1; i_mem_size = 2'b10;
        i_mem_addr = 32'h3000; i_mem_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_mem_req = 1'b0;
        chk_reset_vals("rst_mid_wr");
        ref_mem[32'h3000] = 8'h0D;
        exp_nwr += 1;
        chk("rst_wr_b0", {24'd0, ram_get(32'h3000)}, 32'h0000_000D);
        chk("rst_wr_b1", {24'd0, ram_get(32'h3001)}, {24'd0, ref_rd(32'h3001)});
        chk("rst_wr_count", nwr, exp_nwr);
        i_rst = 1'b0;
        exp_if_inst = 32'h0; exp_mem_rdata = 32'h0; bv = 1'b0;
        @(posedge clk); #1;
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0, -1);

        foreach (ram_mem[k]) chk("ram_image", {24'd0, ram_mem[k]}, {24'd0, ref_rd(k)});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
